// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
//   fetch_state_t : request tracking state of the fetch FSM
//   fetch_entry_t : {pc, instr} pair buffered between memory and decode
//                   (default-width form; fetch_stage builds a
//                   WIDTH-generic equivalent with the same layout)
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no request outstanding
    WAIT    = 2'd1,  // request outstanding, result wanted
    DISCARD = 2'd2   // request outstanding, result dropped on arrival
  } fetch_state_t;

  localparam int FETCH_WIDTH = 16;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with single-cycle flush, used as the prefetch queue.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   flush       : empties the queue next cycle; a pop in the same cycle
//                 still completes (its data was already presented)
//   push, din   : write an entry (ignored when full, flushing or in reset)
//   pop         : remove the head (ignored when empty)
//   dout, valid : head entry and its valid flag (valid = count != 0)
//   count       : occupancy, 0..DEPTH
module sync_fifo #(
  parameter  int WIDTH_E = 32,
  parameter  int DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [WIDTH_E-1:0] din,
  input  logic               pop,
  output logic [WIDTH_E-1:0] dout,
  output logic               valid,
  output logic [CW-1:0]      count
);

  logic [WIDTH_E-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok = push && !flush && !reset && (count != CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign valid   = (count != '0);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, incrementer, branch redirect
// and a prefetch queue feeding decode.
// Ports:
//   CLK, reset          : clock, synchronous active-high reset
//   mem_req/addr/ack/data : instruction memory read; req held until ack,
//                         addr stable while req is high, ack may come in
//                         the same cycle req rises
//   redirect, redirect_pc : taken branch/jump: flush queue, refetch target
//   out_valid/ready/instr/pc : queue head towards decode
//   pc_val              : current fetch PC
//   count               : queue occupancy
//   dbg_state           : fetch FSM state, for observation only
//
// Handshake (decode side): an entry is transferred in every cycle where
// out_valid && out_ready at the rising edge; out_valid depends only on
// registered state, never combinationally on out_ready or redirect. A
// transfer in a redirect cycle is still a delivered entry.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter int               STEP     = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] pc_val,
  output logic [CW-1:0]    count,
  output fetch_state_t     dbg_state
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  fetch_state_t     state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] req_addr;
  logic             issue;
  logic             push;
  logic             pop;
  entry_t           push_entry;
  entry_t           head;

  // A new request only starts from IDLE with room in the queue; since at
  // most one request is ever outstanding, a push can never find it full.
  assign issue    = !reset && (state == IDLE) && (count < CW'(DEPTH)) && !redirect;
  assign mem_req  = issue || (!reset && (state != IDLE));
  assign mem_addr = (state == IDLE) ? pc : req_addr;

  // Data is kept only for a live request that is not being redirected away.
  assign push             = !reset && !redirect && mem_ack && (issue || (state == WAIT));
  assign push_entry.pc    = (state == IDLE) ? pc : req_addr;
  assign push_entry.instr = mem_data;
  assign pop              = out_valid && out_ready;

  sync_fifo #(
    .WIDTH_E (2 * WIDTH),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk   (CLK),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .valid (out_valid),
    .count (count)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign pc_val    = pc;
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
      // An outstanding request must still be retired by its ack; until
      // then its result is unwanted.
      if ((state != IDLE) && mem_ack) state <= IDLE;
      else if (state == WAIT)         state <= DISCARD;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            if (mem_ack) begin
              pc <= pc + STEP_W;
            end else begin
              req_addr <= pc;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            pc    <= pc + STEP_W;
            state <= IDLE;
          end
        end
        DISCARD: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default instance plus a RESET_PC=FFFF
// instance for the wrap case. Memory model: mode 0 zero-wait, mode 1
// ack in the third cycle of a request, mode 2 manual ack. Data returned
// is always address + 16'h0100.
module tb_fetch_stage;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  // ---------------- default instance ----------------
  logic         mem_req, mem_ack, redirect, out_valid, out_ready;
  logic [15:0]  mem_addr, mem_data, redirect_pc, out_instr, out_pc, pc_val;
  logic [2:0]   count;
  fetch_state_t dbg_state;

  fetch_stage dut (
    .CLK(CLK), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .pc_val(pc_val), .count(count), .dbg_state(dbg_state)
  );

  logic [1:0] mode = 2'd0;
  logic       man_ack = 1'b0;
  int         lat_cnt = 0;

  assign mem_ack  = (mode == 2'd0) ? mem_req :
                    (mode == 2'd1) ? (mem_req && (lat_cnt == 2)) : man_ack;
  assign mem_data = mem_addr + 16'h0100;

  always @(posedge CLK) begin
    if (mem_req && !mem_ack) lat_cnt <= lat_cnt + 1;
    else                     lat_cnt <= 0;
  end

  // ---------------- wrap instance ----------------
  logic         w_req, w_valid;
  logic [15:0]  w_addr, w_data, w_instr, w_pc, w_pc_val;
  logic [2:0]   w_count;
  fetch_state_t w_state;

  assign w_data = w_addr + 16'h0100;

  fetch_stage #(.RESET_PC(16'hFFFF)) dut_w (
    .CLK(CLK), .reset(reset),
    .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_req), .mem_data(w_data),
    .redirect(1'b0), .redirect_pc(16'h0000),
    .out_valid(w_valid), .out_ready(1'b1), .out_instr(w_instr), .out_pc(w_pc),
    .pc_val(w_pc_val), .count(w_count), .dbg_state(w_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] exp16;
  int          waited;

  initial begin
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    out_ready   = 1'b1;

    // ---- 1: reset state, then zero-wait streaming ----
    @(negedge CLK);
    check("rst_count",    32'(count),     32'd0);
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_req",      32'(mem_req),   32'd0);
    check("rst_pc",       32'(pc_val),    32'h0000);
    check("rst_state",    32'(dbg_state), 32'(IDLE));
    check("rst_pc_wrap",  32'(w_pc_val),  32'hFFFF);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    check("t1_req",  32'(mem_req),  32'd1);
    check("t1_addr", 32'(mem_addr), 32'h0000);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      check("t1_pc",    32'(out_pc),    32'(k - 1));
      check("t1_instr", 32'(out_instr), 32'h0100 + 32'(k - 1));
      check("t1_count", 32'(count),     32'd1);
      // ---- 5: wrap instance runs the same schedule from FFFF ----
      exp16 = 16'hFFFF + 16'(k - 1);
      check("t5_wrap_pc", 32'(w_pc), 32'(exp16));
      exp16 = exp16 + 16'h0100;
      check("t5_wrap_instr", 32'(w_instr), 32'(exp16));
    end

    // ---- 2: backpressure fills queue, then drain ----
    out_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge CLK);
    check("t2_full_count", 32'(count),   32'd4);
    check("t2_full_req",   32'(mem_req), 32'd0);
    check("t2_full_pc",    32'(pc_val),  32'h0004);
    @(negedge CLK);
    check("t2_hold_count", 32'(count),  32'd4);
    check("t2_hold_head",  32'(out_pc), 32'h0000);
    out_ready = 1'b1;
    #1;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge CLK);
      check("t2_drain_pc",    32'(out_pc),    32'(k));
      check("t2_drain_instr", 32'(out_instr), 32'h0100 + 32'(k));
    end
    check("t2_refill_count", 32'(count), 32'd3);

    // ---- 3: slow memory, redirect while waiting ----
    mode = 2'd1;
    do_reset();
    @(negedge CLK);
    check("t3_wait", 32'(dbg_state), 32'(WAIT));
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge CLK);
    redirect = 1'b0;
    check("t3_discard",      32'(dbg_state), 32'(DISCARD));
    check("t3_pc",           32'(pc_val),    32'h0040);
    check("t3_old_addr",     32'(mem_addr),  32'h0000);
    check("t3_discard_cnt",  32'(count),     32'd0);
    @(negedge CLK);
    check("t3_idle",         32'(dbg_state), 32'(IDLE));
    check("t3_new_addr",     32'(mem_addr),  32'h0040);
    check("t3_dropped_cnt",  32'(count),     32'd0);
    waited = 0;
    while (!out_valid && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    check("t3_valid_timeout", 32'(out_valid), 32'd1);
    check("t3_out_pc",        32'(out_pc),    32'h0040);
    check("t3_out_instr",     32'(out_instr), 32'h0140);

    // ---- 4: redirect coincident with ack and pop ----
    mode      = 2'd0;
    out_ready = 1'b0;
    do_reset();
    repeat (2) @(negedge CLK);
    mode    = 2'd2;
    man_ack = 1'b0;
    @(negedge CLK);
    check("t4_wait",  32'(dbg_state), 32'(WAIT));
    check("t4_count", 32'(count),     32'd2);
    check("t4_addr",  32'(mem_addr),  32'h0002);
    out_ready   = 1'b1;
    man_ack     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    #1;
    check("t4_head_pc",    32'(out_pc),    32'h0000);
    check("t4_head_valid", 32'(out_valid), 32'd1);
    @(negedge CLK);
    redirect = 1'b0;
    man_ack  = 1'b0;
    mode     = 2'd0;
    check("t4_flush_count", 32'(count),     32'd0);
    check("t4_flush_valid", 32'(out_valid), 32'd0);
    check("t4_flush_pc",    32'(pc_val),    32'h0080);
    check("t4_flush_state", 32'(dbg_state), 32'(IDLE));
    @(negedge CLK);
    check("t4_new_pc",    32'(out_pc),    32'h0080);
    check("t4_new_instr", 32'(out_instr), 32'h0180);
    check("t4_new_count", 32'(count),     32'd1);

    // ---- 6: reset in WAIT with three queued entries ----
    out_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge CLK);
    mode    = 2'd2;
    man_ack = 1'b0;
    @(negedge CLK);
    check("t6_wait",  32'(dbg_state), 32'(WAIT));
    check("t6_count", 32'(count),     32'd3);
    reset   = 1'b1;
    man_ack = 1'b1;
    #1;
    check("t6_rst_req", 32'(mem_req), 32'd0);
    @(negedge CLK);
    check("t6_rst_count", 32'(count),     32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_pc",    32'(pc_val),    32'h0000);
    check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge CLK);
    check("t6_late_ack_count", 32'(count), 32'd0);
    reset   = 1'b0;
    man_ack = 1'b0;
    @(negedge CLK);
    check("t6_restart_state", 32'(dbg_state), 32'(WAIT));
    check("t6_restart_addr",  32'(mem_addr),  32'h0000);
    check("t6_restart_count", 32'(count),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
